// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter: I/D block fills and D write-through stores.
// Round-robin on ties, no preemption, fill words returned with their index.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_fill_valid,
  output logic [DATA_W-1:0]            i_fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] i_fill_idx,
  output logic                         i_done,
  output logic                         i_stall,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_fill_valid,
  output logic [DATA_W-1:0]            d_fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] d_fill_idx,
  output logic                         d_done,
  output logic                         d_stall,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rdata_valid
);

  localparam int IW = $clog2(BLK_WORDS);
  localparam int CW = IW + 1;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(2 * BLK_WORDS - 1);
  localparam logic [CW-1:0] N_WORDS = CW'(BLK_WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(BLK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL_I,
    FILL_D,
    WRITE
  } state_e;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]       iss_q, iss_d;
  logic [CW-1:0]       ret_q, ret_d;
  logic [MEM_LAT-1:0]  pend_q, pend_d;

  logic              fill;
  logic              issue;
  logic              ret;
  logic              last_ret;
  logic              grant_i;
  logic [ADDR_W-1:0] base;

  assign fill     = (state_q == FILL_I) || (state_q == FILL_D);
  assign issue    = fill && (iss_q < N_WORDS);
  // Only accept data whose read was issued MEM_LAT cycles ago by this
  // transaction; stale or spurious returns never reach a cache.
  assign ret      = fill && mem_rdata_valid && pend_q[MEM_LAT-1]
                    && (ret_q < N_WORDS);
  assign last_ret = ret && (ret_q == LAST_WORD);
  assign grant_i  = i_req && (!d_req || last_d_q);
  assign base     = addr_q & ~OFS_MASK;
  assign pend_d   = (pend_q << 1) | MEM_LAT'(issue);

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    iss_d        = iss_q;
    ret_d        = ret_q;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_fill_valid = 1'b0;
    i_fill_data  = '0;
    i_fill_idx   = '0;
    i_done       = 1'b0;
    d_fill_valid = 1'b0;
    d_fill_data  = '0;
    d_fill_idx   = '0;
    d_done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        iss_d = '0;
        ret_d = '0;
        if (grant_i) begin
          state_d  = FILL_I;
          addr_d   = i_addr;
          last_d_d = 1'b0;
        end else if (d_req) begin
          state_d  = d_we ? WRITE : FILL_D;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          last_d_d = 1'b1;
        end
      end
      FILL_I, FILL_D: begin
        if (issue) begin
          mem_en   = 1'b1;
          mem_addr = base + ADDR_W'({iss_q, 1'b0});
          iss_d    = iss_q + 1'b1;
        end
        if (ret) begin
          ret_d = ret_q + 1'b1;
          if (state_q == FILL_I) begin
            i_fill_valid = 1'b1;
            i_fill_data  = mem_rdata;
            i_fill_idx   = ret_q[IW-1:0];
            i_done       = last_ret;
          end else begin
            d_fill_valid = 1'b1;
            d_fill_data  = mem_rdata;
            d_fill_idx   = ret_q[IW-1:0];
            d_done       = last_ret;
          end
        end
        if (last_ret) begin
          state_d = IDLE;
          iss_d   = '0;
          ret_d   = '0;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_done    = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      iss_q    <= '0;
      ret_q    <= '0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      iss_q    <= iss_d;
      ret_q    <= ret_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level schedule model vs per-cycle outputs.
// Memory is a fixed-latency pipeline with address-derived data.
module tb_mem_arbiter;
  localparam int LAT = 4;
  localparam int BW  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_fill_valid, i_done, i_stall;
  logic [15:0] i_fill_data;
  logic [2:0]  i_fill_idx;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_fill_valid, d_done, d_stall;
  logic [15:0] d_fill_data;
  logic [2:0]  d_fill_idx;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rdata_valid;

  logic [LAT-1:0] pv = '0;
  logic [15:0]    pd [LAT];
  logic           spur_v = 1'b0;
  logic [15:0]    spur_d = '0;
  logic [15:0]    seed = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .BLK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_fill_valid(i_fill_valid), .i_fill_data(i_fill_data),
    .i_fill_idx(i_fill_idx), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_fill_valid(d_fill_valid), .d_fill_data(d_fill_data),
    .d_fill_idx(d_fill_idx), .d_done(d_done), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid)
  );

  function automatic logic [15:0] memval(input logic [15:0] a);
    return a ^ {a[7:0], a[15:8]} ^ seed;
  endfunction

  // Memory never resets: reads in flight at a reset still come back.
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], mem_en & ~mem_wr};
    pd[0] <= memval(mem_addr);
    for (int j = 1; j < LAT; j++) pd[j] <= pd[j-1];
  end
  assign mem_rdata_valid = pv[LAT-1] | spur_v;
  assign mem_rdata       = spur_v ? spur_d : pd[LAT-1];

  typedef struct packed {
    logic       men;
    logic       mwr;
    logic [15:0] maddr;
    logic [15:0] mwd;
    logic       ifv;
    logic [15:0] ifd;
    logic [2:0] ifi;
    logic       idn;
    logic       ist;
    logic       dfv;
    logic [15:0] dfd;
    logic [2:0] dfi;
    logic       ddn;
    logic       dst;
  } ob_t;

  ob_t  obs   [64];
  ob_t  exp_v [64];
  int   n_cyc;
  int   errs = 0;
  int   checks = 0;
  logic m_last_d = 1'b1;

  function automatic ob_t sample();
    ob_t o;
    o.men = mem_en; o.mwr = mem_wr; o.maddr = mem_addr; o.mwd = mem_wdata;
    o.ifv = i_fill_valid; o.ifd = i_fill_data; o.ifi = i_fill_idx;
    o.idn = i_done; o.ist = i_stall;
    o.dfv = d_fill_valid; o.dfd = d_fill_data; o.dfi = d_fill_idx;
    o.ddn = d_done; o.dst = d_stall;
    return o;
  endfunction

  // Reference schedule: requests arrive at given cycles (-1 = none);
  // grants, issues, returns and done follow from the arbitration rules.
  task automatic build(input int ia, input logic [15:0] iadr, input int da,
                       input logic dwe, input logic [15:0] dadr,
                       input logic [15:0] dwd);
    int t, dn;
    bit ip, dp, ic, dc;
    logic [15:0] b, a;
    for (int c = 0; c < 64; c++) exp_v[c] = '0;
    ip = (ia >= 0);
    dp = (da >= 0);
    t  = 0;
    while (ip || dp) begin
      ic = ip && (ia <= t);
      dc = dp && (da <= t);
      if (!ic && !dc) begin
        t++;
      end else if (ic && (!dc || m_last_d)) begin
        b = iadr & 16'hFFF0;
        for (int k = 0; k < BW; k++) begin
          a = b + 16'(2 * k);
          exp_v[t+1+k].men       = 1'b1;
          exp_v[t+1+k].maddr     = a;
          exp_v[t+1+LAT+k].ifv   = 1'b1;
          exp_v[t+1+LAT+k].ifd   = memval(a);
          exp_v[t+1+LAT+k].ifi   = 3'(k);
        end
        dn = t + LAT + BW;
        exp_v[dn].idn = 1'b1;
        for (int c = ia; c < dn; c++) exp_v[c].ist = 1'b1;
        m_last_d = 1'b0;
        ip = 1'b0;
        t  = dn + 1;
      end else begin
        if (dwe) begin
          dn = t + 1;
          exp_v[dn].men   = 1'b1;
          exp_v[dn].mwr   = 1'b1;
          exp_v[dn].maddr = dadr;
          exp_v[dn].mwd   = dwd;
        end else begin
          b = dadr & 16'hFFF0;
          for (int k = 0; k < BW; k++) begin
            a = b + 16'(2 * k);
            exp_v[t+1+k].men     = 1'b1;
            exp_v[t+1+k].maddr   = a;
            exp_v[t+1+LAT+k].dfv = 1'b1;
            exp_v[t+1+LAT+k].dfd = memval(a);
            exp_v[t+1+LAT+k].dfi = 3'(k);
          end
          dn = t + LAT + BW;
        end
        exp_v[dn].ddn = 1'b1;
        for (int c = da; c < dn; c++) exp_v[c].dst = 1'b1;
        m_last_d = 1'b1;
        dp = 1'b0;
        t  = dn + 1;
      end
    end
    n_cyc = t + 2;
  endtask

  // Requesters raise req at their arrival cycle and drop it after done.
  task automatic run(input int ia, input logic [15:0] iadr, input int da,
                     input logic dwe, input logic [15:0] dadr,
                     input logic [15:0] dwd);
    for (int c = 0; c < n_cyc; c++) begin
      if (c == ia) begin i_req = 1'b1; i_addr = iadr; end
      if (c == da) begin
        d_req = 1'b1; d_we = dwe; d_addr = dadr; d_wdata = dwd;
      end
      @(negedge clk);
      obs[c] = sample();
      @(posedge clk);
      #1;
      if (obs[c].idn) i_req = 1'b0;
      if (obs[c].ddn) begin d_req = 1'b0; d_we = 1'b0; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_last_d = 1'b1;
  endtask

  task automatic test_reset();
    ob_t e;
    @(negedge clk);
    e = sample();
    checks++;
    if (e !== '0) begin
      errs++;
      $display("FAIL reset_idle got %h want 0", e);
    end
    i_req = 1'b1;
    #1;
    e = sample();
    checks++;
    if (e !== ob_t'(1 << 22)) begin
      errs++;
      $display("FAIL reset_stall got %h want %h", e, ob_t'(1 << 22));
    end
    i_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_last_d = 1'b1;
  endtask

  task automatic test_ifill();
    logic [15:0] a;
    for (int r = 0; r < 2; r++) begin
      a = (r == 0) ? 16'h0006 : 16'($urandom);
      build(0, a, -1, 1'b0, 16'h0, 16'h0);
      run(0, a, -1, 1'b0, 16'h0, 16'h0);
      for (int c = 0; c < n_cyc; c++) begin
        checks++;
        if (obs[c] !== exp_v[c]) begin
          errs++;
          $display("FAIL ifill a=%h cyc %0d got %h want %h", a, c, obs[c], exp_v[c]);
        end
      end
    end
  endtask

  task automatic test_write();
    logic [15:0] a, w;
    for (int r = 0; r < 2; r++) begin
      a = (r == 0) ? 16'h0010 : 16'($urandom);
      w = (r == 0) ? 16'hBEEF : 16'($urandom);
      build(-1, 16'h0, 0, 1'b1, a, w);
      run(-1, 16'h0, 0, 1'b1, a, w);
      for (int c = 0; c < n_cyc; c++) begin
        checks++;
        if (obs[c] !== exp_v[c]) begin
          errs++;
          $display("FAIL write a=%h cyc %0d got %h want %h", a, c, obs[c], exp_v[c]);
        end
      end
    end
  endtask

  task automatic test_tie();
    logic [15:0] ia [3];
    logic [15:0] da [3];
    int          iarr [3];
    int          darr [3];
    pulse_reset();
    ia[0] = 16'h0000; da[0] = 16'h0020; iarr[0] = 0; darr[0] = 0;
    ia[1] = 16'($urandom); da[1] = 16'h0; iarr[1] = 0; darr[1] = -1;
    ia[2] = 16'($urandom); da[2] = 16'($urandom); iarr[2] = 0; darr[2] = 0;
    for (int r = 0; r < 3; r++) begin
      build(iarr[r], ia[r], darr[r], 1'b0, da[r], 16'h0);
      run(iarr[r], ia[r], darr[r], 1'b0, da[r], 16'h0);
      for (int c = 0; c < n_cyc; c++) begin
        checks++;
        if (obs[c] !== exp_v[c]) begin
          errs++;
          $display("FAIL tie r%0d cyc %0d got %h want %h", r, c, obs[c], exp_v[c]);
        end
      end
    end
  endtask

  task automatic test_wait();
    logic [15:0] ia, da;
    ia = 16'($urandom);
    da = 16'($urandom);
    build(4, ia, 0, 1'b0, da, 16'h0);
    run(4, ia, 0, 1'b0, da, 16'h0);
    for (int c = 0; c < n_cyc; c++) begin
      checks++;
      if (obs[c] !== exp_v[c]) begin
        errs++;
        $display("FAIL wait cyc %0d got %h want %h", c, obs[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] a, b, da;
    ob_t         e;
    a  = 16'($urandom);
    b  = a & 16'hFFF0;
    da = 16'($urandom);
    i_req  = 1'b1;
    i_addr = a;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 7) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!i_fill_valid || i_fill_idx !== 3'd2 ||
        i_fill_data !== memval(b + 16'h4)) begin
      errs++;
      $display("FAIL rmid_idx2 got v=%b idx=%0d d=%h want v=1 idx=2 d=%h",
               i_fill_valid, i_fill_idx, i_fill_data, memval(b + 16'h4));
    end
    rst   = 1'b1;
    i_req = 1'b0;
    #1;
    e = sample();
    checks++;
    if (e !== '0) begin
      errs++;
      $display("FAIL rmid_zero got %h want 0", e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_last_d = 1'b1;
    build(-1, 16'h0, 1, 1'b0, da, 16'h0);
    run(-1, 16'h0, 1, 1'b0, da, 16'h0);
    for (int c = 0; c < n_cyc; c++) begin
      checks++;
      if (obs[c] !== exp_v[c]) begin
        errs++;
        $display("FAIL rmid_after cyc %0d got %h want %h", c, obs[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_spurious();
    ob_t         e;
    logic [15:0] a, w;
    spur_v = 1'b1;
    spur_d = 16'h1234;
    @(negedge clk);
    e = sample();
    checks++;
    if (e !== '0) begin
      errs++;
      $display("FAIL spurious got %h want 0", e);
    end
    @(posedge clk);
    #1;
    spur_v = 1'b0;
    a = 16'($urandom);
    w = 16'($urandom);
    build(-1, 16'h0, 0, 1'b1, a, w);
    run(-1, 16'h0, 0, 1'b1, a, w);
    for (int c = 0; c < n_cyc; c++) begin
      checks++;
      if (obs[c] !== exp_v[c]) begin
        errs++;
        $display("FAIL spur_after cyc %0d got %h want %h", c, obs[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_random();
    int          ia, da;
    logic        we;
    logic [15:0] iad, dad, wd;
    for (int r = 0; r < 10; r++) begin
      ia  = ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, 12));
      da  = ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, 12));
      if (ia < 0 && da < 0) ia = 0;
      we  = 1'($urandom);
      iad = 16'($urandom);
      dad = 16'($urandom);
      wd  = 16'($urandom);
      build(ia, iad, da, we, dad, wd);
      run(ia, iad, da, we, dad, wd);
      for (int c = 0; c < n_cyc; c++) begin
        checks++;
        if (obs[c] !== exp_v[c]) begin
          errs++;
          $display("FAIL rand r%0d cyc %0d got %h want %h", r, c, obs[c], exp_v[c]);
        end
      end
    end
  endtask

  initial begin
    seed = 16'($urandom);
    rst  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ifill();
    test_write();
    test_tie();
    test_wait();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared main-memory port between the I-cache miss path and the D-cache miss/store path of Memory_Cache.
- Sequences BLK_WORDS-word block fills on a pipelined fixed-latency memory and single-word write-through stores.
- Returns fill words to the requesting cache with a word index.
- Drives per-side stall so the pipeline freezes until the transaction finishes.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.
- MEM_LAT, 4, cycles from read issue to mem_rdata_valid.
- BLK_WORDS, 8, words per cache block (power of 2); block = 2*BLK_WORDS bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  I-cache fill request; held until i_done.
- i_addr  in  ADDR_W  I-side miss byte address.
- i_fill_valid  out  1  fill word present on i_fill_data.
- i_fill_data  out  DATA_W  fill word.
- i_fill_idx  out  log2(BLK_WORDS)  word offset of the fill word within the block.
- i_done  out  1  one-cycle pulse: I transaction complete.
- i_stall  out  1  i_req & ~i_done.
- d_req  in  1  D-side request; held until d_done.
- d_we  in  1  1 = single-word store, 0 = block fill.
- d_addr  in  ADDR_W  D-side byte address.
- d_wdata  in  DATA_W  store data.
- d_fill_valid, d_fill_data, d_fill_idx, d_done, d_stall  out  same as I-side.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  1 = write.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data.
- mem_rdata_valid  in  1  read data valid; occurs exactly MEM_LAT cycles after each read issue.

Behaviour:
- Reset: state=IDLE, issue/return counters=0, last_served=D. All outputs 0; stalls follow their equations.
- States:
  - IDLE: choose a winner among pending requests. On a tie, grant the side not in last_served (round-robin; I wins first after reset). Latch address and d_wdata at grant. D with d_we=1 -> WRITE; D with d_we=0 -> FILL_D; I -> FILL_I. Update last_served. Grant decision takes 1 cycle, so no memory access occurs in the grant cycle.
  - FILL_x:
    - Base = latched address with low log2(BLK_WORDS)+1 bits cleared.
    - Issue cycles k=0..BLK_WORDS-1: mem_en=1, mem_wr=0, mem_addr=base+2k.
    - Each mem_rdata_valid increments the return counter. Same cycle: x_fill_valid=1, x_fill_data=mem_rdata (combinational pass-through), x_fill_idx=return counter.
    - The last return also asserts x_done, and the state goes to IDLE next cycle.
    - Fill length = BLK_WORDS+MEM_LAT cycles after grant.
  - WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=latched addr, mem_wdata=latched data; d_done=1 in the same cycle; next state IDLE.
- No preemption: a started transaction always completes, even if its req drops (illegal requester behaviour, tolerated).
- A request arriving during another transaction waits. It is granted from IDLE on the cycle after the other side's done, so a back-to-back idle gap is exactly 1 cycle.
- mem_rdata_valid outside FILL_x, or beyond BLK_WORDS returns, is ignored. No fill_valid or done is generated for it.
- Reset mid-transaction: immediate return to IDLE, counters cleared. Read data still in flight from memory is discarded. No done is ever generated for an aborted transaction.
- Fill_valid/done are never asserted on the non-granted side. At most one mem access per cycle.
- Counters are log2(BLK_WORDS)+1 bits and do not wrap during a legal fill.
- Address arithmetic is modulo 2^ADDR_W.

Test Plan:
- Reset, then i_req=1, i_addr=16'h0006:
  - grant at T; mem_addr 0000,0002..000E on T+1..T+8;
  - i_fill_valid T+5..T+12 with idx 0..7 and data echoed;
  - i_done at T+12; i_stall low at T+12.
- d_req=1, d_we=1, d_addr=16'h0010, d_wdata=16'hBEEF: single cycle with mem_en=1, mem_wr=1, addr 0010, data BEEF; d_done in the same cycle; d_stall high only for the grant cycle.
- i_req and d_req (fill, addr 16'h0020) raised together after reset:
  - I served first (0000 block); D granted the cycle after i_done; D reads 0020..002E.
  - Repeat the tie: D wins next time.
- D fill in progress with i_req asserted at issue k=3: no I-side memory access or fill_valid until d_done; I grant one cycle later.
- rst pulsed during FILL_I at return idx 2: all outputs 0; remaining mem_rdata_valid pulses produce no fill_valid or done; a new d_req is then served normally.
- Spurious mem_rdata_valid=1 in IDLE with data 16'h1234: no fill_valid, no done, state unchanged.
